// File: rtl/jam_updown_counter.sv
// Presettable up/down counter of NIBBLES 4-bit digits with runtime binary or BCD
// counting and an active-low carry chain for cascading instances.
module jam_updown_counter #(
    parameter int                   NIBBLES     = 2,
    parameter logic [4*NIBBLES-1:0] RESET_VALUE = '0
) (
    input  logic                   CLOCK,
    input  logic                   RESET_N,
    input  logic                   PRESET_ENABLE,
    input  logic [4*NIBBLES-1:0]   JAM,
    input  logic                   CARRY_IN_N,
    input  logic                   UP_DOWN,
    input  logic                   BINARY_DECADE,
    output logic [4*NIBBLES-1:0]   Q,
    output logic                   CARRY_OUT_N
);
    localparam int W = 4 * NIBBLES;

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic [W-1:0] binaryNext;
    logic [W-1:0] decadeNext;
    logic         decadeCarry;
    logic         terminalCount;

    // A nibble steps only while every lower nibble sits on its terminal digit;
    // the carry left over after the top nibble is the decade terminal count.
    always_comb begin
        decadeNext  = count_q;
        decadeCarry = 1'b1;
        for (int k = 0; k < NIBBLES; k++) begin
            if (decadeCarry) begin
                if (UP_DOWN) begin
                    decadeNext[4*k +: 4] = (count_q[4*k +: 4] >= 4'd9) ? 4'd0
                                                                      : count_q[4*k +: 4] + 4'd1;
                end else begin
                    decadeNext[4*k +: 4] = (count_q[4*k +: 4] == 4'd0) ? 4'd9
                                                                      : count_q[4*k +: 4] - 4'd1;
                end
            end
            decadeCarry = decadeCarry & (UP_DOWN ? (count_q[4*k +: 4] >= 4'd9)
                                                 : (count_q[4*k +: 4] == 4'd0));
        end
    end

    always_comb begin
        binaryNext    = UP_DOWN ? count_q + W'(1) : count_q - W'(1);
        terminalCount = BINARY_DECADE ? (UP_DOWN ? (&count_q) : (count_q == '0))
                                      : decadeCarry;
        count_d = count_q;
        if (PRESET_ENABLE) begin
            count_d = JAM;
        end else if (!CARRY_IN_N) begin
            count_d = BINARY_DECADE ? binaryNext : decadeNext;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            count_q <= RESET_VALUE;
        end else begin
            count_q <= count_d;
        end
    end

    // Carry-out is combinational so a following stage steps on the same edge.
    assign Q           = count_q;
    assign CARRY_OUT_N = ~(~CARRY_IN_N & terminalCount);

endmodule

// File: tb/tb_jam_updown_counter.sv
// Self-checking bench: a 2-digit counter against a digit-list model, plus a two-stage
// cascade of 1-digit counters against a plain 0..99 integer model.
module tb_jam_updown_counter;
    logic       clk = 1'b0;
    logic       rstN, pe, cin, up, bd;
    logic [7:0] jam;
    logic [7:0] q;
    logic       co;

    logic       casPe, casCin;
    logic [7:0] casJam;
    logic [3:0] loQ, hiQ;
    logic       loCo, hiCo;

    int testsRun = 0;
    int testsFailed = 0;

    logic [7:0] modelQ;
    int         casModel;
    logic       modelValid = 1'b0;
    logic       countWraps = 1'b0;
    int         wraps = 0;

    always #5 clk = ~clk;

    jam_updown_counter #(.NIBBLES(2), .RESET_VALUE(8'h00)) dut (
        .CLOCK(clk), .RESET_N(rstN), .PRESET_ENABLE(pe), .JAM(jam),
        .CARRY_IN_N(cin), .UP_DOWN(up), .BINARY_DECADE(bd),
        .Q(q), .CARRY_OUT_N(co)
    );

    jam_updown_counter #(.NIBBLES(1), .RESET_VALUE(4'h0)) casLo (
        .CLOCK(clk), .RESET_N(rstN), .PRESET_ENABLE(casPe), .JAM(casJam[3:0]),
        .CARRY_IN_N(casCin), .UP_DOWN(1'b1), .BINARY_DECADE(1'b0),
        .Q(loQ), .CARRY_OUT_N(loCo)
    );

    jam_updown_counter #(.NIBBLES(1), .RESET_VALUE(4'h0)) casHi (
        .CLOCK(clk), .RESET_N(rstN), .PRESET_ENABLE(casPe), .JAM(casJam[7:4]),
        .CARRY_IN_N(loCo), .UP_DOWN(1'b1), .BINARY_DECADE(1'b0),
        .Q(hiQ), .CARRY_OUT_N(hiCo)
    );

    // Decade step on a digit list: clear terminal digits from the bottom until one
    // digit can absorb the step.
    function automatic logic [7:0] decadeStep(input logic [7:0] v, input logic goUp);
        int digits[2];
        logic [7:0] r;
        digits[0] = int'(v[3:0]);
        digits[1] = int'(v[7:4]);
        for (int i = 0; i < 2; i++) begin
            if (goUp) begin
                if (digits[i] >= 9) digits[i] = 0;
                else begin digits[i] = digits[i] + 1; break; end
            end else begin
                if (digits[i] == 0) digits[i] = 9;
                else begin digits[i] = digits[i] - 1; break; end
            end
        end
        r = {4'(digits[1]), 4'(digits[0])};
        return r;
    endfunction

    function automatic logic expectedCarryN(input logic [7:0] v, input logic cinN,
                                            input logic goUp, input logic binary);
        logic tc;
        if (!goUp)      tc = (v == 8'h00);
        else if (binary) tc = (v == 8'hFF);
        else            tc = (v[7:4] >= 4'd9) && (v[3:0] >= 4'd9);
        return !(cinN == 1'b0 && tc);
    endfunction

    function automatic int bcdToInt(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    // Reference models advance on every edge from the sampled inputs.
    always @(posedge clk) begin
        if (!rstN) begin
            modelQ     = 8'h00;
            casModel   = 0;
            modelValid = 1'b1;
        end else if (modelValid) begin
            if (pe)        modelQ = jam;
            else if (!cin) modelQ = bd ? modelQ + 8'd1 - (up ? 8'd0 : 8'd2) : decadeStep(modelQ, up);
            if (casPe)        casModel = bcdToInt(casJam);
            else if (!casCin) casModel = (casModel + 1) % 100;
            if (countWraps && !casCin && !casPe && hiCo == 1'b0) wraps++;
        end
    end

    task automatic compare(input string name, input logic [7:0] actual, input logic [7:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the models on the falling edge.
    always @(negedge clk) begin
        if (modelValid) begin
            compare("model Q", q, modelQ);
            compare("model CARRY_OUT_N", {7'd0, co}, {7'd0, expectedCarryN(modelQ, cin, up, bd)});
            compare("cascade Q", {hiQ, loQ}, {4'(casModel / 10), 4'(casModel % 10)});
        end
    end

    task automatic applyStimulus(input int edges);
        repeat (edges) @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] expQ, input logic expCo);
        compare({name, " Q"}, q, expQ);
        compare({name, " CARRY_OUT_N"}, {7'd0, co}, {7'd0, expCo});
    endtask

    task automatic load(input logic [7:0] value);
        pe = 1'b1; jam = value;
        applyStimulus(1);
        pe = 1'b0;
    endtask

    initial begin
        rstN = 1'b0; pe = 1'b1; jam = 8'h55; cin = 1'b1; up = 1'b1; bd = 1'b1;
        casPe = 1'b0; casCin = 1'b1; casJam = 8'h00;
        applyStimulus(2);
        checkOutput("reset", 8'h00, 1'b1);

        rstN = 1'b1;
        load(8'hFD);
        cin = 1'b0;
        checkOutput("bin load FD", 8'hFD, 1'b1);
        applyStimulus(1); checkOutput("bin FE", 8'hFE, 1'b1);
        applyStimulus(1); checkOutput("bin FF", 8'hFF, 1'b0);
        applyStimulus(1); checkOutput("bin wrap 00", 8'h00, 1'b1);
        applyStimulus(1); checkOutput("bin 01", 8'h01, 1'b1);

        up = 1'b0;
        load(8'h00);
        checkOutput("bin down at 00", 8'h00, 1'b0);
        applyStimulus(1); checkOutput("bin down wrap FF", 8'hFF, 1'b1);

        up = 1'b1; bd = 1'b0;
        load(8'h98);
        applyStimulus(1); checkOutput("dec 99", 8'h99, 1'b0);
        applyStimulus(1); checkOutput("dec wrap 00", 8'h00, 1'b1);
        applyStimulus(1); checkOutput("dec 01", 8'h01, 1'b1);
        load(8'h19);
        applyStimulus(1); checkOutput("dec 19 to 20", 8'h20, 1'b1);
        load(8'h3B);
        applyStimulus(1); checkOutput("dec illegal up 3B", 8'h40, 1'b1);

        up = 1'b0;
        load(8'h01);
        applyStimulus(1); checkOutput("dec down 00", 8'h00, 1'b0);
        applyStimulus(1); checkOutput("dec down wrap 99", 8'h99, 1'b1);
        load(8'h0C);
        applyStimulus(1); checkOutput("dec illegal 0B", 8'h0B, 1'b1);
        applyStimulus(1); checkOutput("dec illegal 0A", 8'h0A, 1'b1);
        applyStimulus(1); checkOutput("dec illegal 09", 8'h09, 1'b1);

        cin = 1'b1;
        applyStimulus(5); checkOutput("hold", 8'h09, 1'b1);

        cin = 1'b0; pe = 1'b1; jam = 8'h42;
        applyStimulus(1); checkOutput("preset over count", 8'h42, 1'b1);
        rstN = 1'b0; jam = 8'h77;
        applyStimulus(1); checkOutput("reset over preset", 8'h00, 1'b0);
        rstN = 1'b1; pe = 1'b0; cin = 1'b1;

        casPe = 1'b1; casJam = 8'h09;
        applyStimulus(1);
        casPe = 1'b0; casCin = 1'b0;
        applyStimulus(1);
        compare("cascade 09 to 10", {hiQ, loQ}, 8'h10);

        casPe = 1'b1; casJam = 8'h00; casCin = 1'b1;
        applyStimulus(1);
        casPe = 1'b0; casCin = 1'b0; countWraps = 1'b1;
        applyStimulus(100);
        countWraps = 1'b0; casCin = 1'b1;
        compare("cascade 100 edges", {hiQ, loQ}, 8'h00);
        compare("cascade wrap count", 8'(wraps), 8'd1);

        applyStimulus(1);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
